// File: rtl/dma_sram_arb.sv
// dma_sram_arb: single-port SRAM arbiter with a block-copy DMA engine.
// The CPU port always wins; the DMA copies len words src->dst in the
// cycles the CPU leaves free (RD -> CAP -> WR per word).
// Optional build macro: DMA_STALL_CNT_EN adds a saturating stall counter
// on dma_stalls; without it dma_stalls is tied to 0.
module dma_sram_arb #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ADDR,
  input  logic [DW-1:0] cpu_DI,
  input  logic          cpu_EN,
  input  logic          cpu_WE,
  output logic [DW-1:0] cpu_DO,
  output logic [AW-1:0] sram_ADDR,
  output logic [DW-1:0] sram_DI,
  output logic          sram_EN,
  output logic          sram_WE,
  input  logic [DW-1:0] sram_DO,
  input  logic          dma_start,
  input  logic [AW-1:0] dma_src,
  input  logic [AW-1:0] dma_dst,
  input  logic [AW-1:0] dma_len,
  output logic          dma_busy,
  output logic          dma_done,
  output logic [15:0]   dma_stalls
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [AW-1:0] idx_nxt;

  // Read data returns straight from the SRAM; no extra latency for the CPU.
  assign cpu_DO  = sram_DO;
  assign idx_nxt = idx_q + AW'(1);

  assign dma_busy = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);
  assign dma_done = (state_q == S_DONE);

  // State and copy-context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic and SRAM arbitration; a CPU request overrides the DMA
  // and freezes it in RD/WR for that cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    buf_d     = buf_q;
    sram_ADDR = '0;
    sram_DI   = '0;
    sram_EN   = 1'b0;
    sram_WE   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          src_d   = dma_src;
          dst_d   = dma_dst;
          len_d   = dma_len;
          idx_d   = '0;
          state_d = (dma_len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if (!cpu_EN) begin
          sram_EN   = 1'b1;
          sram_ADDR = src_q + idx_q;
          state_d   = S_CAP;
        end
      end
      S_CAP: begin
        // SRAM is free for the CPU this cycle; the DMA only captures data.
        buf_d   = sram_DO;
        state_d = S_WR;
      end
      S_WR: begin
        if (!cpu_EN) begin
          sram_EN   = 1'b1;
          sram_WE   = 1'b1;
          sram_ADDR = dst_q + idx_q;
          sram_DI   = buf_q;
          idx_d     = idx_nxt;
          state_d   = (idx_nxt == len_q) ? S_DONE : S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cpu_EN) begin
      sram_ADDR = cpu_ADDR;
      sram_DI   = cpu_DI;
      sram_EN   = 1'b1;
      sram_WE   = cpu_WE;
    end
  end

`ifdef DMA_STALL_CNT_EN
  logic [15:0] stalls_q, stalls_d;

  // Stall counter: cycles the DMA wanted the SRAM but the CPU held it.
  always_comb begin
    stalls_d = stalls_q;
    if (state_q == S_IDLE && dma_start)
      stalls_d = '0;
    else if ((state_q == S_RD || state_q == S_WR) && cpu_EN && stalls_q != 16'hFFFF)
      stalls_d = stalls_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stalls_q <= '0;
    else       stalls_q <= stalls_d;
  end

  assign dma_stalls = stalls_q;
`else
  assign dma_stalls = '0;
`endif

endmodule

// File: tb/tb_dma_sram_arb.sv
// Bench for dma_sram_arb: behavioural SRAM, a step-queue model of the copy
// engine, a per-cycle compare process and hand-computed literal checks.
module tb_dma_sram_arb;

  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] cpu_ADDR = '0;
  logic [31:0] cpu_DI = '0;
  logic        cpu_EN = 0;
  logic        cpu_WE = 0;
  logic [31:0] cpu_DO;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI;
  logic        sram_EN;
  logic        sram_WE;
  logic [31:0] sram_DO = '0;
  logic        dma_start = 0;
  logic [15:0] dma_src = '0;
  logic [15:0] dma_dst = '0;
  logic [15:0] dma_len = '0;
  logic        dma_busy;
  logic        dma_done;
  logic [15:0] dma_stalls;

  dma_sram_arb #(.AW(16), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_ADDR(cpu_ADDR), .cpu_DI(cpu_DI), .cpu_EN(cpu_EN), .cpu_WE(cpu_WE), .cpu_DO(cpu_DO),
    .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE), .sram_DO(sram_DO),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_stalls(dma_stalls)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment SRAM (one-cycle read latency) and the model's expected image.
  logic [31:0] mem     [0:65535];
  logic [31:0] exp_mem [0:65535];

  always @(posedge clk) begin
    if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR] <= sram_DI;
      else         sram_DO <= mem[sram_ADDR];
    end
  end

  // Model: an accepted start expands into a list of steps; RD/WR steps stall
  // while the CPU holds the SRAM, every other step takes one cycle.
  localparam int K_RD = 0, K_CAP = 1, K_WR = 2, K_DONE = 3;
  typedef struct { int kind; logic [15:0] addr; } step_t;
  step_t       mq[$];
  logic [31:0] mbuf = '0;
  int          mstall = 0;
  logic        rd_pend = 0;
  logic [31:0] rd_val = '0;

  always @(posedge clk) begin
    rd_pend = cpu_EN && !cpu_WE;
    rd_val  = exp_mem[cpu_ADDR];
    if (reset) begin
      mq.delete();
      mstall = 0;
    end else if (mq.size() > 0) begin
      step_t h;
      h = mq[0];
      if ((h.kind == K_RD || h.kind == K_WR) && cpu_EN) begin
        if (mstall < 65535) mstall++;
      end else begin
        if (h.kind == K_RD) mbuf = exp_mem[h.addr];
        if (h.kind == K_WR) exp_mem[h.addr] = mbuf;
        void'(mq.pop_front());
      end
    end else if (dma_start) begin
      mstall = 0;
      for (int i = 0; i < int'(dma_len); i++) begin
        mq.push_back('{K_RD,  16'(dma_src + 16'(i))});
        mq.push_back('{K_CAP, 16'h0});
        mq.push_back('{K_WR,  16'(dma_dst + 16'(i))});
      end
      mq.push_back('{K_DONE, 16'h0});
    end
    if (cpu_EN && cpu_WE) exp_mem[cpu_ADDR] = cpu_DI;
  end

  // Per-cycle compare against the model, plus bookkeeping counters.
  logic        run_cmp = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          dma_acc = 0;
  logic [15:0] rd_log[$];

  always @(negedge clk) begin
    if (run_cmp) begin
      int          k;
      logic        e_en, e_we;
      logic [15:0] e_addr;
      logic [31:0] e_di;
      logic [15:0] e_st;
      k      = (mq.size() > 0) ? mq[0].kind : -1;
      e_en   = 0; e_we = 0; e_addr = '0; e_di = '0;
      if (cpu_EN) begin
        e_en = 1; e_we = cpu_WE; e_addr = cpu_ADDR; e_di = cpu_DI;
      end else if (k == K_RD) begin
        e_en = 1; e_addr = mq[0].addr;
      end else if (k == K_WR) begin
        e_en = 1; e_we = 1; e_addr = mq[0].addr; e_di = mbuf;
      end
`ifdef DMA_STALL_CNT_EN
      e_st = 16'(mstall);
`else
      e_st = 16'h0;
`endif
      chk("sram_EN",   {31'b0, sram_EN}, {31'b0, e_en});
      chk("sram_WE",   {31'b0, sram_WE}, {31'b0, e_we});
      chk("sram_ADDR", {16'b0, sram_ADDR}, {16'b0, e_addr});
      if (!(e_en && !e_we && !cpu_EN)) chk("sram_DI", sram_DI, e_di);
      chk("dma_busy",  {31'b0, dma_busy}, {31'b0, (k == K_RD || k == K_CAP || k == K_WR)});
      chk("dma_done",  {31'b0, dma_done}, {31'b0, (k == K_DONE)});
      chk("dma_stalls", {16'b0, dma_stalls}, {16'b0, e_st});
      if (rd_pend) chk("cpu_DO", cpu_DO, rd_val);
      if (dma_busy) busy_cnt++;
      if (dma_done) done_cnt++;
      if (sram_EN && !cpu_EN) begin
        dma_acc++;
        if (!sram_WE) rd_log.push_back(sram_ADDR);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] v);
    mem[a] = v; exp_mem[a] = v;
  endtask

  task automatic start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    dma_src = s; dma_dst = d; dma_len = l; dma_start = 1;
    tick();
    dma_start = 0;
  endtask

  // Bounded wait for the next dma_done pulse; exits in the following IDLE cycle.
  task automatic wait_done(input string nm);
    int n0, k;
    n0 = done_cnt; k = 0;
    while (done_cnt == n0 && k < 300) begin tick(); k++; end
    chk(nm, done_cnt - n0, 1);
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 32'hDEAD0000 | i; exp_mem[i] = 32'hDEAD0000 | i;
    end
    for (int i = 0; i < 8; i++) poke(16'(16'h10 + i), 32'hA0 + i);
    tick(); tick();
    run_cmp = 1;
    reset = 0;
    @(negedge clk);
    chk("rst_busy", {31'b0, dma_busy}, 0);
    chk("rst_done", {31'b0, dma_done}, 0);
    chk("rst_stalls", {16'b0, dma_stalls}, 0);
    tick();

    // Idle copy.
    busy_cnt = 0; done_cnt = 0;
    start(16'h10, 16'h40, 16'd4);
    wait_done("idle_done");
    chk("idle_busy_cycles", busy_cnt, 12);
    chk("idle_done_pulses", done_cnt, 1);
    for (int i = 0; i < 4; i++) chk("idle_data", mem[16'h40 + i], 32'hA0 + i);

    // CPU contention: CPU reads 0x0000 every other cycle, one write to 0x0200.
    start(16'h10, 16'h44, 16'd4);
    for (int c = 0; c < 14; c++) begin
      cpu_EN   = (c % 2) == 0;
      cpu_WE   = (c == 6);
      cpu_ADDR = (c == 6) ? 16'h0200 : 16'h0000;
      cpu_DI   = 32'h1234;
      tick();
    end
    cpu_EN = 0; cpu_WE = 0;
    wait_done("cont_done");
    for (int i = 0; i < 4; i++) chk("cont_data", mem[16'h44 + i], 32'hA0 + i);
    chk("cont_cpu_wr", mem[16'h0200], 32'h1234);

    // Zero length: DONE in the cycle right after the start edge, no access.
    dma_acc = 0;
    start(16'h10, 16'h70, 16'd0);
    @(negedge clk);
    chk("len0_done", {31'b0, dma_done}, 1);
    chk("len0_busy", {31'b0, dma_busy}, 0);
    tick(); tick();
    chk("len0_no_access", dma_acc, 0);

    // Second start mid-copy with changed parameters is ignored.
    start(16'h10, 16'h50, 16'd4);
    tick(); tick(); tick();
    dma_src = 16'h30; dma_dst = 16'h60; dma_len = 16'd2; dma_start = 1;
    tick();
    dma_start = 0;
    wait_done("ign_done");
    for (int i = 0; i < 4; i++) chk("ign_data", mem[16'h50 + i], 32'hA0 + i);
    chk("ign_untouched", mem[16'h60], 32'hDEAD0060);

    // Wrap-around of the source address.
    poke(16'hFFFE, 32'h11); poke(16'hFFFF, 32'h22); poke(16'h0000, 32'h33); poke(16'h0001, 32'h44);
    rd_log.delete();
    start(16'hFFFE, 16'h0100, 16'd4);
    wait_done("wrap_done");
    chk("wrap_nreads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap_rd0", {16'b0, rd_log[0]}, 32'hFFFE);
      chk("wrap_rd1", {16'b0, rd_log[1]}, 32'hFFFF);
      chk("wrap_rd2", {16'b0, rd_log[2]}, 32'h0000);
      chk("wrap_rd3", {16'b0, rd_log[3]}, 32'h0001);
    end
    chk("wrap_wr0", mem[16'h0100], 32'h11);
    chk("wrap_wr3", mem[16'h0103], 32'h44);

    // Reset abort while the third word is being read: words 0 and 1 done.
    start(16'h10, 16'h80, 16'd8);
    repeat (6) tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("abort_busy", {31'b0, dma_busy}, 0);
    tick();
    chk("abort_w0", mem[16'h80], 32'hA0);
    chk("abort_w1", mem[16'h81], 32'hA1);
    for (int i = 2; i < 8; i++) chk("abort_untouched", mem[16'h80 + i], 32'hDEAD0000 | (32'h80 + i));
    start(16'h10, 16'h90, 16'd2);
    wait_done("post_abort_done");
    chk("post_abort_w1", mem[16'h91], 32'hA1);

    // Overlapping ranges propagate the first word forward.
    poke(16'h20, 1); poke(16'h21, 2); poke(16'h22, 3);
    start(16'h20, 16'h21, 16'd2);
    wait_done("ovl_done");
    chk("ovl_21", mem[16'h21], 1);
    chk("ovl_22", mem[16'h22], 1);

    tick(); tick();
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) diffs++;
    chk("mem_image_diffs", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_sram_arb.md
# dma_sram_arb

Single-port SRAM arbiter with built-in block-copy DMA engine, placed between the processor control unit and the SRAM in the SP top level. The CPU port has absolute priority and sees the SRAM exactly as if directly connected. The DMA engine copies `len` consecutive 32-bit words from `src` to `dst` using only the cycles in which the CPU is not accessing the SRAM.

## Interface
Parameters:
- `AW`, 16: SRAM address width; also the width of `src`, `dst` and `len`.
- `DW`, 32: SRAM data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_ADDR`  in  AW  CPU SRAM address.
- `cpu_DI`  in  DW  CPU write data.
- `cpu_EN`  in  1  CPU access request.
- `cpu_WE`  in  1  CPU write enable (qualified by `cpu_EN`).
- `cpu_DO`  out  DW  read data to CPU; wired directly to `sram_DO`.
- `sram_ADDR`  out  AW  SRAM address.
- `sram_DI`  out  DW  SRAM write data.
- `sram_EN`  out  1  SRAM enable.
- `sram_WE`  out  1  SRAM write enable.
- `sram_DO`  in  DW  SRAM read data; valid the cycle after the read is sampled.
- `dma_start`  in  1  start pulse; sampled only in IDLE.
- `dma_src`  in  AW  source base address; captured on an accepted start.
- `dma_dst`  in  AW  destination base address; captured on an accepted start.
- `dma_len`  in  AW  word count; captured on an accepted start.
- `dma_busy`  out  1  high in RD, CAP and WR.
- `dma_done`  out  1  one-cycle pulse in the DONE state.
- `dma_stalls`  out  16  stall counter (see Configuration).

## Operation
- **Arbitration (combinational).**
  - If `cpu_EN` = 1, the SRAM outputs equal the CPU inputs.
  - Otherwise, in RD or WR, the DMA drives the SRAM.
  - Otherwise, all SRAM outputs are 0.
  - The CPU is never stalled. The DMA waits in its current state while `cpu_EN` = 1.
- **FSM states:** IDLE, RD, CAP, WR, DONE.
  - IDLE: `dma_start` = 1 captures `src`, `dst`, `len` and clears `idx` to 0. If `len` = 0, go to DONE; otherwise go to RD.
  - RD: when `cpu_EN` = 0, drive EN=1, WE=0, ADDR=`src+idx`, then go to CAP. If `cpu_EN` = 1, stay in RD.
  - CAP: latch `sram_DO` into the data buffer and go to WR. No SRAM request is made. CPU access in this cycle is permitted.
  - WR: when `cpu_EN` = 0, drive EN=1, WE=1, ADDR=`dst+idx`, DI=buffer, then increment `idx`. Go to DONE if `idx+1` = `len`, else go to RD. If `cpu_EN` = 1, stay in WR.
  - DONE: `dma_done` = 1, then go to IDLE.
- **Arithmetic.** Address sums are AW bits and wrap modulo 2^AW (0xFFFF+1 → 0x0000). `idx` is AW bits.
- **Ordering.** Copies run in ascending order, one word at a time. Overlapping ranges with `dst` > `src` propagate earlier words; this is defined behaviour, not an error.
- **Start handling.** `dma_start` is ignored outside IDLE. While busy, changes on `dma_src`, `dma_dst` and `dma_len` have no effect.
- **Reset.**
  - FSM goes to IDLE; `idx`, buffer and captured registers clear to 0.
  - Outputs after reset: `dma_busy` = 0, `dma_done` = 0, `dma_stalls` = 0.
  - SRAM outputs follow the CPU inputs, or 0 when `cpu_EN` = 0.
  - Reset during a copy aborts it: no further DMA writes occur, and words already written stay written.

## Timing
- Start accepted at edge T: RD is active in cycle T+1.
- Without contention, each word takes exactly 3 cycles (RD, CAP, WR).
- For `len` = N with no contention:
  - `dma_busy` is high for 3N cycles.
  - `dma_done` pulses in the cycle after the final WR.
  - The next start is accepted one cycle later.
- `len` = 0: DONE follows the start immediately and no SRAM access is made.
- Each cycle with `cpu_EN` = 1 while in RD or WR adds exactly one cycle of latency.
- `cpu_DO` has zero added latency. The read-data cycle after a DMA read (CAP) does not block the CPU.

## Configuration
- `DMA_STALL_CNT_EN`
  - Defined: `dma_stalls` counts cycles in RD or WR with `cpu_EN` = 1. It saturates at 0xFFFF and clears on reset and on an accepted start.
  - Undefined: `dma_stalls` is constant 0 and no counter logic is built.

## Test plan
- **Idle copy.** Preload mem[0x10..0x13] = 0xA0..0xA3; start src=0x10, dst=0x40, len=4, `cpu_EN` = 0 throughout → mem[0x40..0x43] = 0xA0..0xA3; `dma_busy` high for exactly 12 cycles; `dma_done` pulses once.
- **CPU contention.** Same copy with `cpu_EN` = 1 on alternate cycles (CPU reads 0x00) →
  - every CPU access is served unchanged and CPU read data is correct;
  - the copy completes correctly;
  - with the macro defined, `dma_stalls` equals the number of RD/WR cycles that had `cpu_EN` = 1.
- **Zero length and ignored start.**
  - `len` = 0 → `dma_done` pulses at T+1, `sram_EN` never driven by the DMA.
  - A second start issued mid-copy → ignored; the original parameters complete.
- **Wrap-around.** src=0xFFFE, dst=0x0100, len=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in that order and writes 0x0100..0x0103.
- **Reset abort.** Assert reset in cycle 5 of a len=8 copy → `dma_busy` = 0 the next cycle; dst words 0 and 1 are written, words 2..7 untouched; a new start after reset completes normally.
- **Overlap.** mem[0x20..0x22] = 1,2,3; src=0x20, dst=0x21, len=2 → mem[0x21] = 1, mem[0x22] = 1.
